bird_flight_ctrl: RTL and testbench
===================================

// Module: bird_flight_ctrl
// PURPOSE
//  Bird vertical-motion engine feeding the VGA top level: owns the bird bounding box
//  (Bird_X_L/X_R/Y_T/Y_B) consumed by the Bird pixel compare and by obstacle_logic.
//  Applies gravity once per frame tick and a fixed jump impulse per button press.
//  Runs the Initial/Flight/Stop game phases and freezes on Stop (collision lose).
// PARAMETERS
//  BIRD_X      100  fixed left X of bird (pixels)
//  BIRD_W      16   bird width; Bird_X_R = BIRD_X + BIRD_W - 1
//  BIRD_H      16   bird height; Bird_Y_B = Bird_Y_T + BIRD_H - 1
//  Y_INIT      232  Bird_Y_T after reset / Ack
//  GRAVITY     1    velocity increment per Tick (pixels/tick)
//  JUMP_VEL    8    magnitude of upward velocity loaded on jump
//  MAX_FALL    10   positive (downward) velocity ceiling
//  FLOOR_Y     479  lowest legal Bird_Y_B
//  VEL_W       6    signed velocity width
// PORTS
//  Clk         in   1      system clock
//  reset       in   1      asynchronous, active-high reset
//  Tick        in   1      one-Clk pulse per physics step (frame rate)
//  Start       in   1      level; leave Initial
//  Ack         in   1      level; leave Stop, reload Initial
//  Stop        in   1      level; collision lose from obstacle_logic
//  BtnPress    in   1      raw async jump button
//  Bird_X_L    out  10     bird left edge
//  Bird_X_R    out  10     bird right edge
//  Bird_Y_T    out  10     bird top edge
//  Bird_Y_B    out  10     bird bottom edge
//  Velocity    out  VEL_W  signed current velocity (+ = down)
//  Floor_Hit   out  1      sticky: bird reached floor this round
//  q_Initial   out  1      one-hot state
//  q_Flight    out  1      one-hot state
//  q_Stop      out  1      one-hot state
// BEHAVIOUR
//  Reset (async, any time, incl. mid-flight): state=Initial, Y_T=Y_INIT, Velocity=0,
//   Floor_Hit=0, jump_pending=0, sync flops=0. X_L/X_R are constants always.
//  BtnPress: 2-flop sync then rising-edge detect -> sets jump_pending (sticky until
//   consumed). Multiple edges between Ticks = one jump. Held button = one jump.
//  Initial: outputs hold reset values; jump_pending forced 0. Start=1 -> Flight next Clk.
//  Flight, priority order each Clk:
//   1) Stop=1 -> Stop state; no position/velocity update that cycle even if Tick=1.
//   2) Tick=1: v' = jump_pending ? -JUMP_VEL : min(Velocity+GRAVITY, MAX_FALL);
//      y' = Y_T + v' computed 11-bit signed; jump_pending cleared (edge arriving same
//      Clk as Tick is consumed by this Tick).
//      y' < 0 -> Y_T=0, Velocity=0 (ceiling bump, no lose).
//      y' + BIRD_H - 1 >= FLOOR_Y -> Y_T=FLOOR_Y-BIRD_H+1, Velocity=0, Floor_Hit=1,
//      state=Stop.  Else Y_T=y', Velocity=v'. Registered: new values visible Clk after Tick.
//  Stop: all position outputs frozen; Tick/BtnPress ignored. Ack=1 -> Initial with
//   Y_T=Y_INIT, Velocity=0, Floor_Hit=0, jump_pending=0 loaded on same edge.
//  Start and Ack are levels: Start held in Initial after Ack re-enters Flight next Clk
//   (intended: BtnD drives both).
//  Y_B derived combinationally from registered Y_T; no X wrap; Y never leaves 0..FLOOR_Y.
// STRUCTURE
//  flappy_pkg.vh: state encodings (ST_INITIAL/ST_FLIGHT/ST_STOP), SCREEN_W=640,
//   SCREEN_H=480, FLOOR_Y default, bird size defaults shared with obstacle_logic.
//  Sub-module btn_edge_sync (2-flop sync + rising-edge pulse), reusable for all Btn*.
//  Main FSM, velocity/position datapath in this module.
// TESTING
//  Reset -> Y_T=232, Y_B=247, X_L=100, X_R=115, Velocity=0, q_Initial=1.
//  Start, 3 Ticks no press -> Velocity 1,2,3; Y_T 233,235,238.
//  From Y_T=238 v=3: press then Tick -> Velocity=-8, Y_T=230; press+Tick same Clk -> jump taken.
//  Repeated jumps from Y_T=10 -> Y_T=0, Velocity=0, still q_Flight; velocity capped at 10.
//  Free fall to floor -> Y_T=464, Y_B=479, Floor_Hit=1, q_Stop; later Ticks no change.
//  Stop=1 with Tick same Clk -> Y_T unchanged, q_Stop; Ack -> Y_T=232; reset mid-Flight -> Initial.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants and state encodings, used by the bird engine
// and by obstacle_logic so that both agree on screen and bird geometry.
package flappy_pkg;

  // One-hot phase encoding, so each state bit can drive its q_* output directly
  typedef enum logic [2:0] {
    ST_INITIAL = 3'b001,
    ST_FLIGHT  = 3'b010,
    ST_STOP    = 3'b100
  } state_e;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int FLOOR_Y_DEF  = SCREEN_H - 1;
  localparam int BIRD_X_DEF   = 100;
  localparam int BIRD_W_DEF   = 16;
  localparam int BIRD_H_DEF   = 16;
  localparam int Y_INIT_DEF   = 232;
  localparam int GRAVITY_DEF  = 1;
  localparam int JUMP_VEL_DEF = 8;
  localparam int MAX_FALL_DEF = 10;
  localparam int VEL_W_DEF    = 6;

endpackage

// File: rtl/btn_edge_sync.sv
// Brings an asynchronous push button into the clock domain through two flops
// and emits a single-cycle pulse on each synchronised rising edge.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic rise_pulse
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;
  logic       prev_q;
  logic       prev_d;

  // Shift the raw button through the synchroniser and keep the last settled level
  always_comb begin
    sync_d = {sync_q[0], btn_in};
    prev_d = sync_q[1];
  end

  // Synchroniser and edge-history flops, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[1] & ~prev_q;

endmodule

// File: rtl/bird_flight_ctrl.sv
// Bird vertical-motion engine: game phase FSM plus velocity/position datapath.
// Gravity is applied once per Tick, a button press queues one upward impulse,
// and everything freezes once the round is lost.
module bird_flight_ctrl
  import flappy_pkg::*;
#(
  parameter int BIRD_X   = BIRD_X_DEF,
  parameter int BIRD_W   = BIRD_W_DEF,
  parameter int BIRD_H   = BIRD_H_DEF,
  parameter int Y_INIT   = Y_INIT_DEF,
  parameter int GRAVITY  = GRAVITY_DEF,
  parameter int JUMP_VEL = JUMP_VEL_DEF,
  parameter int MAX_FALL = MAX_FALL_DEF,
  parameter int FLOOR_Y  = FLOOR_Y_DEF,
  parameter int VEL_W    = VEL_W_DEF
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    Tick,
  input  logic                    Start,
  input  logic                    Ack,
  input  logic                    Stop,
  input  logic                    BtnPress,
  output logic [9:0]              Bird_X_L,
  output logic [9:0]              Bird_X_R,
  output logic [9:0]              Bird_Y_T,
  output logic [9:0]              Bird_Y_B,
  output logic signed [VEL_W-1:0] Velocity,
  output logic                    Floor_Hit,
  output logic                    q_Initial,
  output logic                    q_Flight,
  output logic                    q_Stop
);

  localparam logic [9:0]              X_LEFT      = 10'(BIRD_X);
  localparam logic [9:0]              X_RIGHT     = 10'(BIRD_X + BIRD_W - 1);
  localparam logic [9:0]              Y_START     = 10'(Y_INIT);
  localparam logic [9:0]              Y_SPAN      = 10'(BIRD_H - 1);
  localparam logic [9:0]              FLOOR_TOP   = 10'(FLOOR_Y - BIRD_H + 1);
  localparam logic signed [10:0]      FLOOR_TOP_S = 11'(FLOOR_Y - BIRD_H + 1);
  localparam logic signed [VEL_W-1:0] JUMP_V      = VEL_W'(-JUMP_VEL);
  localparam logic signed [VEL_W-1:0] GRAV_V      = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] MAX_V       = VEL_W'(MAX_FALL);

  state_e                  state_q, state_d;
  logic [9:0]              y_q, y_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    floor_hit_q, floor_hit_d;
  logic                    pending_q, pending_d;

  logic                    btn_rise;
  logic                    jump_now;
  logic signed [VEL_W-1:0] vel_inc;
  logic signed [VEL_W-1:0] vel_fall;
  logic signed [VEL_W-1:0] vel_next;
  logic signed [10:0]      vel_ext;
  logic signed [10:0]      y_calc;

  btn_edge_sync u_btn_sync (
    .clk        (Clk),
    .rst        (reset),
    .btn_in     (BtnPress),
    .rise_pulse (btn_rise)
  );

  // Candidate physics step: jump impulse or capped gravity, applied to the top edge
  // in 11-bit signed arithmetic so that overshoot above the screen is detectable
  always_comb begin
    jump_now = pending_q | btn_rise;
    vel_inc  = vel_q + GRAV_V;
    vel_fall = (vel_inc > MAX_V) ? MAX_V : vel_inc;
    vel_next = jump_now ? JUMP_V : vel_fall;
    vel_ext  = {{(11 - VEL_W){vel_next[VEL_W-1]}}, vel_next};
    y_calc   = signed'({1'b0, y_q}) + vel_ext;
  end

  // Phase sequencing and the per-Tick position/velocity update
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    vel_d       = vel_q;
    floor_hit_d = floor_hit_q;
    pending_d   = pending_q;
    unique case (state_q)
      ST_INITIAL: begin
        y_d         = Y_START;
        vel_d       = '0;
        floor_hit_d = 1'b0;
        pending_d   = 1'b0;
        if (Start) state_d = ST_FLIGHT;
      end
      ST_FLIGHT: begin
        if (Stop) begin
          state_d = ST_STOP;
        end else if (Tick) begin
          pending_d = 1'b0;
          if (y_calc < 0) begin
            y_d   = '0;
            vel_d = '0;
          end else if (y_calc >= FLOOR_TOP_S) begin
            y_d         = FLOOR_TOP;
            vel_d       = '0;
            floor_hit_d = 1'b1;
            state_d     = ST_STOP;
          end else begin
            y_d   = y_calc[9:0];
            vel_d = vel_next;
          end
        end else begin
          pending_d = pending_q | btn_rise;
        end
      end
      ST_STOP: begin
        pending_d = 1'b0;
        if (Ack) begin
          state_d     = ST_INITIAL;
          y_d         = Y_START;
          vel_d       = '0;
          floor_hit_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INITIAL;
      end
    endcase
  end

  // Game state registers, returned to the Initial pose by the asynchronous reset
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INITIAL;
      y_q         <= Y_START;
      vel_q       <= '0;
      floor_hit_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      vel_q       <= vel_d;
      floor_hit_q <= floor_hit_d;
      pending_q   <= pending_d;
    end
  end

  assign Bird_X_L  = X_LEFT;
  assign Bird_X_R  = X_RIGHT;
  assign Bird_Y_T  = y_q;
  assign Bird_Y_B  = y_q + Y_SPAN;
  assign Velocity  = vel_q;
  assign Floor_Hit = floor_hit_q;
  assign q_Initial = (state_q == ST_INITIAL);
  assign q_Flight  = (state_q == ST_FLIGHT);
  assign q_Stop    = (state_q == ST_STOP);

endmodule

// File: tb/tb_bird_flight_ctrl.sv
// Testbench for bird_flight_ctrl: a behavioural model of the game rules is
// compared against the DUT every cycle, with directed scenarios pinning
// known literal values and a randomized soak at the end.
module tb_bird_flight_ctrl;

  logic              Clk = 1'b0;
  logic              reset;
  logic              Tick, Start, Ack, Stop, BtnPress;
  logic [9:0]        Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
  logic signed [5:0] Velocity;
  logic              Floor_Hit, q_Initial, q_Flight, q_Stop;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: phase 0=Initial, 1=Flight, 2=Stop
  int modelY     = 232;
  int modelVel   = 0;
  int modelPhase = 0;
  bit modelFloor = 1'b0;
  bit modelPend  = 1'b0;
  bit btnHist0   = 1'b0;
  bit btnHist1   = 1'b0;
  bit btnHist2   = 1'b0;
  bit compareEn  = 1'b0;

  // 100 MHz-style free-running clock
  always #5 Clk = ~Clk;

  bird_flight_ctrl dut (
    .Clk       (Clk),
    .reset     (reset),
    .Tick      (Tick),
    .Start     (Start),
    .Ack       (Ack),
    .Stop      (Stop),
    .BtnPress  (BtnPress),
    .Bird_X_L  (Bird_X_L),
    .Bird_X_R  (Bird_X_R),
    .Bird_Y_T  (Bird_Y_T),
    .Bird_Y_B  (Bird_Y_B),
    .Velocity  (Velocity),
    .Floor_Hit (Floor_Hit),
    .q_Initial (q_Initial),
    .q_Flight  (q_Flight),
    .q_Stop    (q_Stop)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle worth of inputs at a falling edge and wait for the next one
  task automatic applyStimulus(input bit tick, input bit start, input bit ack,
                               input bit stop, input bit btn);
    Tick     = tick;
    Start    = start;
    Ack      = ack;
    Stop     = stop;
    BtnPress = btn;
    @(negedge Clk);
  endtask

  // Queue a fresh button edge so that it lands on the same clock as the Tick
  task automatic jumpOnce();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
  endtask

  // Reference model: the button edge seen at a clock is the level sampled two
  // clocks earlier rising over the one sampled three clocks earlier
  always @(posedge Clk or posedge reset) begin
    bit pulse;
    int nv;
    int ny;
    if (reset) begin
      modelY     <= 232;
      modelVel   <= 0;
      modelPhase <= 0;
      modelFloor <= 1'b0;
      modelPend  <= 1'b0;
      btnHist0   <= 1'b0;
      btnHist1   <= 1'b0;
      btnHist2   <= 1'b0;
    end else begin
      pulse = btnHist1 && !btnHist2;
      btnHist2 <= btnHist1;
      btnHist1 <= btnHist0;
      btnHist0 <= BtnPress;
      case (modelPhase)
        0: begin
          modelPend  <= 1'b0;
          modelY     <= 232;
          modelVel   <= 0;
          modelFloor <= 1'b0;
          if (Start) modelPhase <= 1;
        end
        1: begin
          if (Stop) begin
            modelPhase <= 2;
          end else if (Tick) begin
            modelPend <= 1'b0;
            if (modelPend || pulse) nv = -8;
            else nv = (modelVel + 1 > 10) ? 10 : modelVel + 1;
            ny = modelY + nv;
            if (ny < 0) begin
              modelY   <= 0;
              modelVel <= 0;
            end else if (ny + 15 >= 479) begin
              modelY     <= 464;
              modelVel   <= 0;
              modelFloor <= 1'b1;
              modelPhase <= 2;
            end else begin
              modelY   <= ny;
              modelVel <= nv;
            end
          end else if (pulse) begin
            modelPend <= 1'b1;
          end
        end
        default: begin
          modelPend <= 1'b0;
          if (Ack) begin
            modelPhase <= 0;
            modelY     <= 232;
            modelVel   <= 0;
            modelFloor <= 1'b0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clk) begin
    if (compareEn) begin
      checkOutput("cmp_X_L", int'(Bird_X_L), 100);
      checkOutput("cmp_X_R", int'(Bird_X_R), 115);
      checkOutput("cmp_Y_T", int'(Bird_Y_T), modelY);
      checkOutput("cmp_Y_B", int'(Bird_Y_B), modelY + 15);
      checkOutput("cmp_Velocity", int'(Velocity), modelVel);
      checkOutput("cmp_Floor_Hit", int'(Floor_Hit), int'(modelFloor));
      checkOutput("cmp_q_Initial", int'(q_Initial), int'(modelPhase == 0));
      checkOutput("cmp_q_Flight", int'(q_Flight), int'(modelPhase == 1));
      checkOutput("cmp_q_Stop", int'(q_Stop), int'(modelPhase == 2));
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized soak
  initial begin
    int iter;
    reset    = 1'b1;
    Tick     = 1'b0;
    Start    = 1'b0;
    Ack      = 1'b0;
    Stop     = 1'b0;
    BtnPress = 1'b0;
    repeat (2) @(negedge Clk);
    reset     = 1'b0;
    compareEn = 1'b1;

    checkOutput("rst_Y_T", int'(Bird_Y_T), 232);
    checkOutput("rst_Y_B", int'(Bird_Y_B), 247);
    checkOutput("rst_X_L", int'(Bird_X_L), 100);
    checkOutput("rst_X_R", int'(Bird_X_R), 115);
    checkOutput("rst_Velocity", int'(Velocity), 0);
    checkOutput("rst_q_Initial", int'(q_Initial), 1);

    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("start_q_Flight", int'(q_Flight), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fall1_Velocity", int'(Velocity), 1);
    checkOutput("fall1_Y_T", int'(Bird_Y_T), 233);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fall2_Velocity", int'(Velocity), 2);
    checkOutput("fall2_Y_T", int'(Bird_Y_T), 235);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fall3_Velocity", int'(Velocity), 3);
    checkOutput("fall3_Y_T", int'(Bird_Y_T), 238);

    repeat (4) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("jump_Velocity", int'(Velocity), -8);
    checkOutput("jump_Y_T", int'(Bird_Y_T), 230);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("held_Velocity", int'(Velocity), -7);
    checkOutput("held_Y_T", int'(Bird_Y_T), 223);

    jumpOnce();
    checkOutput("sameclk_Velocity", int'(Velocity), -8);
    checkOutput("sameclk_Y_T", int'(Bird_Y_T), 215);

    iter = 0;
    while (Bird_Y_T != 10'd0 && iter < 40) begin
      jumpOnce();
      iter++;
    end
    checkOutput("ceil_Y_T", int'(Bird_Y_T), 0);
    checkOutput("ceil_Velocity", int'(Velocity), 0);
    checkOutput("ceil_q_Flight", int'(q_Flight), 1);
    applyStimulus(0, 0, 0, 0, 0);

    repeat (12) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("cap_Velocity", int'(Velocity), 10);
    checkOutput("cap_Y_T", int'(Bird_Y_T), 75);

    iter = 0;
    while (!q_Stop && iter < 100) begin
      applyStimulus(1, 0, 0, 0, 0);
      iter++;
    end
    checkOutput("floor_Y_T", int'(Bird_Y_T), 464);
    checkOutput("floor_Y_B", int'(Bird_Y_B), 479);
    checkOutput("floor_Floor_Hit", int'(Floor_Hit), 1);
    checkOutput("floor_q_Stop", int'(q_Stop), 1);
    repeat (3) applyStimulus(1, 0, 0, 0, 1);
    checkOutput("frozen_Y_T", int'(Bird_Y_T), 464);
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("ack_Y_T", int'(Bird_Y_T), 232);
    checkOutput("ack_Floor_Hit", int'(Floor_Hit), 0);
    checkOutput("ack_q_Initial", int'(q_Initial), 1);

    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("stop_Y_T", int'(Bird_Y_T), 235);
    checkOutput("stop_q_Stop", int'(q_Stop), 1);
    checkOutput("stop_Floor_Hit", int'(Floor_Hit), 0);

    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("ackstart_q_Initial", int'(q_Initial), 1);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("ackstart_q_Flight", int'(q_Flight), 1);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reflight_Y_T", int'(Bird_Y_T), 233);

    reset = 1'b1;
    #1;
    checkOutput("async_q_Initial", int'(q_Initial), 1);
    checkOutput("async_Y_T", int'(Bird_Y_T), 232);
    checkOutput("async_Velocity", int'(Velocity), 0);
    @(negedge Clk);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      bit tick, start, ack, stop, btn;
      tick  = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 3) == 0);
      ack   = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 47) == 0);
      btn   = ($urandom_range(0, 5) == 0) ? ~BtnPress : BtnPress;
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        reset = 1'b0;
      end
      applyStimulus(tick, start, ack, stop, btn);
    end

    compareEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
